// File: rtl/reservoir_valve_sequencer.sv
// Sequences valve changes so that at most one valve moves per STAGGER_CYCLES window, with closes before opens.
// The first toggle lands one edge after a mismatch in IDLE. There is no backpressure. VALVE_SEQ_FAULT_EN adds the sensor-sanity monitor.
module reservoir_valve_sequencer #(
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] fr_req,
  input  logic       dfr_req,
  input  logic [2:0] s,
  output logic [3:0] valve_o,
  output logic       busy_o,
  output logic       fault_o,
  output logic [7:0] change_cnt
);

  typedef enum logic {IDLE, SETTLE} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STAGGER_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       target;
  logic [3:0]       close_mask;
  logic [3:0]       open_mask;
  logic [3:0]       flip;
  logic             mismatch;
  logic             do_toggle;

  assign target     = fault_o ? 4'b1111 : {dfr_req, fr_req};
  assign close_mask = valve_o & ~target;
  assign open_mask  = ~valve_o & target;
  assign mismatch   = (valve_o != target);
  assign busy_o     = (state == SETTLE) | mismatch;
  // Target is only acted on in IDLE or once the stagger window has expired.
  assign do_toggle  = mismatch && ((state == IDLE) || (cnt == '0));

  // Highest pending close wins; otherwise the lowest pending open.
  always_comb begin
    flip = 4'b0000;
    if (close_mask != 4'b0000) begin
      for (int i = 0; i < 4; i++)
        if (close_mask[i]) flip = 4'b0001 << i;
    end else begin
      for (int i = 3; i >= 0; i--)
        if (open_mask[i]) flip = 4'b0001 << i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      valve_o    <= 4'b0000;
      change_cnt <= 8'h00;
    end else begin
      if (do_toggle) begin
        valve_o <= valve_o ^ flip;
        cnt     <= RELOAD;
        state   <= SETTLE;
        if (change_cnt != 8'hFF) change_cnt <= change_cnt + 8'd1;
      end else begin
        case (state)
          IDLE:   state <= IDLE;
          SETTLE: begin
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
            else           state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef VALVE_SEQ_FAULT_EN
  logic       s_valid;
  logic       prev_bad;
  logic [1:0] good_run;

  // A healthy sensor stack reads as a thermometer code from the bottom up.
  assign s_valid = (s == 3'b000) || (s == 3'b001) || (s == 3'b011) || (s == 3'b111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_o  <= 1'b0;
      prev_bad <= 1'b0;
      good_run <= 2'd0;
    end else begin
      prev_bad <= !s_valid;
      if (!s_valid) begin
        good_run <= 2'd0;
        if (prev_bad) fault_o <= 1'b1;
      end else if (good_run != 2'd3) begin
        good_run <= good_run + 2'd1;
      end else begin
        fault_o <= 1'b0;
      end
    end
  end
`else
  logic unused_s;
  assign unused_s = ^s;
  assign fault_o  = 1'b0;
`endif

endmodule

// File: tb/tb_reservoir_valve_sequencer.sv
// Directed and random stimulus against a time-based reference model of the valve sequencer.
// The same bench works with and without VALVE_SEQ_FAULT_EN.
module tb_reservoir_valve_sequencer;
  localparam int STAG = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] fr_req = 3'b000;
  logic       dfr_req = 1'b0;
  logic [2:0] s = 3'b000;
  logic [3:0] valve_o;
  logic       busy_o;
  logic       fault_o;
  logic [7:0] change_cnt;

  reservoir_valve_sequencer #(.STAGGER_CYCLES(STAG), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .fr_req(fr_req), .dfr_req(dfr_req), .s(s),
    .valve_o(valve_o), .busy_o(busy_o), .fault_o(fault_o), .change_cnt(change_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a toggle is allowed whenever STAG edges have passed since the last one.
  int         e = 0;
  int         last_t = -1000;
  logic [3:0] m_valve = 4'b0000;
  logic       m_fault = 1'b0;
  int         m_cnt = 0;
  int         bad_run = 0;
  int         good_run = 0;

  function automatic logic code_ok(input logic [2:0] c);
    return (c == 3'b000) || (c == 3'b001) || (c == 3'b011) || (c == 3'b111);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_t   = -1000;
    m_valve  = 4'b0000;
    m_fault  = 1'b0;
    m_cnt    = 0;
    bad_run  = 0;
    good_run = 0;
  endtask

  task automatic compare_all();
    logic [3:0] tgt;
    logic       exp_busy;
    tgt = m_fault ? 4'hF : {dfr_req, fr_req};
    exp_busy = (tgt != m_valve) || (rst_n && (e - last_t < STAG));
    chk("valve",  {4'b0, valve_o}, {4'b0, m_valve});
    chk("fault",  {7'b0, fault_o}, {7'b0, m_fault});
    chk("count",  change_cnt, 8'(m_cnt));
    chk("busy",   {7'b0, busy_o}, {7'b0, exp_busy});
  endtask

  task automatic step();
    logic [3:0] tgt;
    int b;
    tgt = m_fault ? 4'hF : {dfr_req, fr_req};
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      e++;
      if (tgt != m_valve && (e - last_t) >= STAG) begin
        b = -1;
        for (int i = 3; i >= 0; i--) if (m_valve[i] && !tgt[i] && b < 0) b = i;
        if (b < 0) for (int i = 0; i < 4; i++) if (!m_valve[i] && tgt[i] && b < 0) b = i;
        m_valve[b] = ~m_valve[b];
        last_t = e;
        if (m_cnt < 255) m_cnt++;
      end
`ifdef VALVE_SEQ_FAULT_EN
      if (code_ok(s)) begin
        good_run++;
        bad_run = 0;
        if (good_run >= 4) m_fault = 1'b0;
      end else begin
        bad_run++;
        good_run = 0;
        if (bad_run >= 2) m_fault = 1'b1;
      end
`endif
    end
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2;
    chk("rst_valve", {4'b0, valve_o}, 8'h00);
    chk("rst_cnt", change_cnt, 8'h00);
    chk("rst_fault", {7'b0, fault_o}, 8'h00);
    chk("rst_busy", {7'b0, busy_o}, 8'h00);
    run(2);
    rst_n = 1'b1;

    // Ascending opens, STAG edges apart.
    fr_req = 3'b111;
    run(1);  chk("open1", {4'b0, valve_o}, 8'h01);
    run(4);  chk("open2", {4'b0, valve_o}, 8'h03);
    run(4);  chk("open3", {4'b0, valve_o}, 8'h07);
    run(3);  chk("settle_busy", {7'b0, busy_o}, 8'h01);
    run(1);  chk("idle_busy", {7'b0, busy_o}, 8'h00);
    chk("cnt3", change_cnt, 8'h03);

    // Descending closes.
    fr_req = 3'b001;
    run(1);  chk("close1", {4'b0, valve_o}, 8'h03);
    run(4);  chk("close2", {4'b0, valve_o}, 8'h01);
    chk("cnt5", change_cnt, 8'h05);
    run(4);

    // Closes before the open.
    fr_req = 3'b011;
    run(5);
    fr_req = 3'b000; dfr_req = 1'b1;
    run(1);  chk("mix1", {4'b0, valve_o}, 8'h01);
    run(4);  chk("mix2", {4'b0, valve_o}, 8'h00);
    run(4);  chk("mix3", {4'b0, valve_o}, 8'h08);
    run(4);

    // Target change mid-window waits for the window to end.
    dfr_req = 1'b0; fr_req = 3'b111;
    run(13); chk("to0111", {4'b0, valve_o}, 8'h07);
    run(1);
    fr_req = 3'b000;
    run(2);  chk("hold_window", {4'b0, valve_o}, 8'h07);
    run(1);  chk("window_end", {4'b0, valve_o}, 8'h03);

    // Asynchronous reset mid-SETTLE.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valve", {4'b0, valve_o}, 8'h00);
    chk("arst_cnt", change_cnt, 8'h00);
    chk("arst_fault", {7'b0, fault_o}, 8'h00);
    run(2);
    rst_n = 1'b1;

`ifdef VALVE_SEQ_FAULT_EN
    s = 3'b010;
    run(1);  chk("fault_not_yet", {7'b0, fault_o}, 8'h00);
    run(1);  chk("fault_set", {7'b0, fault_o}, 8'h01);
    run(1);  chk("fault_fill", {4'b0, valve_o}, 8'h01);
    run(5);
    s = 3'b011;
    run(3);  chk("fault_hold", {7'b0, fault_o}, 8'h01);
    run(1);  chk("fault_clear", {7'b0, fault_o}, 8'h00);
    run(30);
`endif

    // Saturation of the toggle counter.
    fr_req = 3'b000; dfr_req = 1'b0; s = 3'b000;
    run(20);
    for (int k = 0; k < 300; k++) begin
      fr_req = fr_req ^ 3'b001;
      run(STAG);
    end
    chk("cnt_sat", change_cnt, 8'hFF);

    // Random phase.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        fr_req  = 3'($urandom_range(0, 7));
        dfr_req = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 5) == 0) s = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 3) == 0) s = 3'b011;
      if (k == 700) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rnd_arst", {4'b0, valve_o}, 8'h00);
        run(1);
        rst_n = 1'b1;
      end
      run(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
